spi_bus_arbiter: RTL
====================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares the single SPIMasterCS engine between the LTC2668 DAC driver and the LTC2494 ADC driver.
//  Grants the bus to one requester per CS transaction (round-robin).
//  Muxes that requester's MOSI stream and byte count into the master and routes MISO bytes back to it.
//  Steers the master's CS onto a dedicated per-device chip select and enforces an inter-transaction guard gap.
// PARAMETERS
//  COUNT_W       5     width of byte-count buses (matches master count width)
//  GUARD_CLKS    4     idle clocks, both CS high, between successive grants (>=1)
//  TIMEOUT_CLKS  1024  clocks without MOSIdv/MISOdv/CS edge before a granted transaction is aborted
// PORTS
//  i_FPGA_clk        in   1        system clock; all logic on rising edge
//  i_FPGA_rst        in   1        synchronous reset, active low
//  i_DAC_req         in   1        DAC driver requests a transaction
//  i_DAC_count       in   COUNT_W  bytes in DAC transaction, sampled at grant
//  i_DAC_MOSI        in   8        DAC byte to send
//  i_DAC_MOSIdv      in   1        DAC byte valid
//  o_DAC_MOSI_ready  out  1        master ready, qualified by DAC grant
//  o_DAC_grant       out  1        DAC owns the bus
//  o_DAC_MISO        out  8        received byte for DAC
//  o_DAC_MISOdv      out  1        received byte valid, DAC
//  o_DAC_done        out  1        1-clk pulse: DAC transaction finished or aborted
//  i_ADC_* / o_ADC_* same set as DAC, for ADC
//  o_MOSI_count      out  COUNT_W  to master i_MOSI_count
//  o_MOSI            out  8        to master i_MOSI
//  o_MOSIdv          out  1        to master i_MOSIdv
//  i_MOSI_ready      in   1        from master o_MOSI_ready
//  i_MISOdv          in   1        from master o_MISOdv
//  i_MISO            in   8        from master o_MISO
//  i_SPI_CS          in   1        from master o_SPI_CS (active low)
//  o_DAC_CS          out  1        DAC chip select, active low
//  o_ADC_CS          out  1        ADC chip select, active low
//  o_busy            out  1        state != IDLE
//  o_timeout         out  1        1-clk pulse on abort
// BEHAVIOUR
//  Reset values:
//   - grants=0, o_*_CS=1, all dv/done/timeout=0, o_MOSI=0, o_MOSI_count=0.
//   - State=IDLE, last_served=ADC, so DAC wins the first tie.
//  States: IDLE -> GRANT -> XFER -> DONE -> GUARD -> IDLE.
//  IDLE:
//   - Sample reqs. One req: grant it. Both reqs: grant the one != last_served.
//   - Register grant and latch its count into o_MOSI_count; next state GRANT.
//   - A latched count of 0 skips the bus entirely: goes straight to DONE, no CS activity.
//  GRANT:
//   - Mux is live from this cycle, combinationally:
//     - o_MOSI/o_MOSIdv = granted requester's byte/dv.
//     - o_X_MOSI_ready = i_MOSI_ready & grant_X.
//   - Wait for i_SPI_CS=0, then XFER.
//  XFER:
//   - Count accepted bytes (o_MOSIdv & i_MOSI_ready).
//   - When i_SPI_CS returns to 1 with bytes_sent == latched count, go to DONE.
//   - A CS rising edge with bytes_sent < count is an inter-byte gap: stay in XFER.
//  DONE:
//   - 1-clk o_X_done for the owner; update last_served; drop grant.
//   - Then GUARD for GUARD_CLKS cycles, then IDLE.
//  Routing (combinational):
//   - o_X_MISO = i_MISO and o_X_MISOdv = i_MISOdv & grant_X.
//   - o_X_CS = grant_X ? i_SPI_CS : 1.
//   - Non-granted requester sees ready=0 and dv=0; its MOSIdv is ignored.
//  req changes while a transaction is granted are ignored; req is sampled only in IDLE.
//  Timeout:
//   - Counter runs in GRANT/XFER and clears on any dv or i_SPI_CS edge.
//   - At TIMEOUT_CLKS: o_timeout pulse with done, grant dropped, CS forced high, then GUARD.
//  Reset mid-transaction: next edge restores all reset values; both CS high immediately.
//  Never both grants high; o_DAC_CS & o_ADC_CS never both 0.
// TESTING
//  - DAC-only req, count=4, master model streams 4 bytes -> o_DAC_grant 1 clk after req; o_DAC_CS mirrors i_SPI_CS; one o_DAC_done; o_ADC_CS stays 1.
//  - DAC and ADC req in same cycle after reset -> DAC first; ADC granted exactly GUARD_CLKS+1 clks after o_DAC_done.
//  - Both req held continuously for 4 transactions -> grants alternate DAC,ADC,DAC,ADC.
//  - ADC count=3, MISO bytes 0xA5,0x5A,0xC3 -> appear only on o_ADC_MISO with o_ADC_MISOdv; o_DAC_MISOdv stays 0.
//  - Granted requester stalls (no dv) -> o_timeout and o_X_done at TIMEOUT_CLKS; o_X_CS=1; next grant allowed after guard.
//  - Drive i_FPGA_rst=0 in mid-XFER -> next edge: grants 0, both CS 1, o_busy 0; tie after release grants DAC.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of the single SPI master between the LTC2668 DAC
// and LTC2494 ADC drivers, with per-device CS steering, guard gap and stall timeout.
module spi_bus_arbiter #(
    parameter int unsigned COUNT_W      = 5,
    parameter int unsigned GUARD_CLKS   = 4,
    parameter int unsigned TIMEOUT_CLKS = 1024
) (
    input  logic               i_FPGA_clk,
    input  logic               i_FPGA_rst,
    input  logic               i_DAC_req,
    input  logic [COUNT_W-1:0] i_DAC_count,
    input  logic [7:0]         i_DAC_MOSI,
    input  logic               i_DAC_MOSIdv,
    output logic               o_DAC_MOSI_ready,
    output logic               o_DAC_grant,
    output logic [7:0]         o_DAC_MISO,
    output logic               o_DAC_MISOdv,
    output logic               o_DAC_done,
    input  logic               i_ADC_req,
    input  logic [COUNT_W-1:0] i_ADC_count,
    input  logic [7:0]         i_ADC_MOSI,
    input  logic               i_ADC_MOSIdv,
    output logic               o_ADC_MOSI_ready,
    output logic               o_ADC_grant,
    output logic [7:0]         o_ADC_MISO,
    output logic               o_ADC_MISOdv,
    output logic               o_ADC_done,
    output logic [COUNT_W-1:0] o_MOSI_count,
    output logic [7:0]         o_MOSI,
    output logic               o_MOSIdv,
    input  logic               i_MOSI_ready,
    input  logic               i_MISOdv,
    input  logic [7:0]         i_MISO,
    input  logic               i_SPI_CS,
    output logic               o_DAC_CS,
    output logic               o_ADC_CS,
    output logic               o_busy,
    output logic               o_timeout
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned GD_W = $clog2(GUARD_CLKS + 1);

    typedef enum logic [2:0] {IDLE, GRANT, XFER, DONE, GUARD} state_t;
    state_t state, next_state;

    logic               owner_adc;
    logic               last_adc;
    logic               timed_out;
    logic               cs_q;
    logic [COUNT_W-1:0] bytes_sent;
    logic [TO_W-1:0]    idle_cnt;
    logic [GD_W-1:0]    guard_cnt;

    logic               in_xact;
    logic               grant_dac;
    logic               grant_adc;
    logic               any_req;
    logic               pick_adc;
    logic [COUNT_W-1:0] req_count;
    logic               accept;
    logic               activity;
    logic               cs_rise;
    logic               expire;

    always_ff @(posedge i_FPGA_clk) begin
        if (!i_FPGA_rst) begin
            state        <= IDLE;
            owner_adc    <= 1'b0;
            last_adc     <= 1'b1;
            timed_out    <= 1'b0;
            cs_q         <= 1'b1;
            bytes_sent   <= '0;
            idle_cnt     <= '0;
            guard_cnt    <= '0;
            o_MOSI_count <= '0;
        end else begin
            state <= next_state;
            cs_q  <= i_SPI_CS;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_adc    <= pick_adc;
                        o_MOSI_count <= req_count;
                        bytes_sent   <= '0;
                        idle_cnt     <= '0;
                        timed_out    <= 1'b0;
                    end
                end
                GRANT, XFER: begin
                    if (accept) bytes_sent <= bytes_sent + 1'b1;
                    idle_cnt  <= activity ? '0 : idle_cnt + 1'b1;
                    timed_out <= expire;
                end
                DONE: begin
                    last_adc  <= owner_adc;
                    guard_cnt <= '0;
                end
                GUARD: guard_cnt <= guard_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // DONE plus GUARD_CLKS-1 GUARD cycles plus the IDLE sampling cycle form the gap
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (any_req) next_state = (req_count == '0) ? DONE : GRANT;
            GRANT: begin
                if (expire)         next_state = DONE;
                else if (!i_SPI_CS) next_state = XFER;
            end
            XFER:  if (expire || (cs_rise && bytes_sent == o_MOSI_count)) next_state = DONE;
            DONE:  next_state = (GUARD_CLKS > 1) ? GUARD : IDLE;
            GUARD: if (guard_cnt == GD_W'(GUARD_CLKS - 2)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_xact   = (state == GRANT) || (state == XFER);
        grant_dac = in_xact && !owner_adc;
        grant_adc = in_xact &&  owner_adc;

        any_req   = i_DAC_req || i_ADC_req;
        pick_adc  = i_ADC_req && (!i_DAC_req || !last_adc);
        req_count = pick_adc ? i_ADC_count : i_DAC_count;

        o_DAC_grant = grant_dac;
        o_ADC_grant = grant_adc;
        o_MOSI      = grant_adc ? i_ADC_MOSI : (grant_dac ? i_DAC_MOSI : '0);
        o_MOSIdv    = (grant_dac && i_DAC_MOSIdv) || (grant_adc && i_ADC_MOSIdv);

        o_DAC_MOSI_ready = i_MOSI_ready && grant_dac;
        o_ADC_MOSI_ready = i_MOSI_ready && grant_adc;
        o_DAC_MISO       = i_MISO;
        o_ADC_MISO       = i_MISO;
        o_DAC_MISOdv     = i_MISOdv && grant_dac;
        o_ADC_MISOdv     = i_MISOdv && grant_adc;

        // Reset gates CS directly so both devices deselect before the reset edge
        o_DAC_CS = (grant_dac && i_FPGA_rst) ? i_SPI_CS : 1'b1;
        o_ADC_CS = (grant_adc && i_FPGA_rst) ? i_SPI_CS : 1'b1;

        o_DAC_done = (state == DONE) && !owner_adc;
        o_ADC_done = (state == DONE) &&  owner_adc;
        o_timeout  = (state == DONE) && timed_out;
        o_busy     = (state != IDLE);

        accept   = o_MOSIdv && i_MOSI_ready;
        cs_rise  = !cs_q && i_SPI_CS;
        activity = o_MOSIdv || i_MISOdv || (cs_q != i_SPI_CS);
        expire   = in_xact && !activity && (idle_cnt == TO_W'(TIMEOUT_CLKS - 1));
    end

endmodule
